// File: rtl/ysyx_22050368_lsu_pkg.sv
// Shared types and helpers for the load/store unit: access sizes, FSM states,
// error causes and the captured-request record.
package ysyx_22050368_lsu_pkg;

  typedef enum logic [1:0] {
    SIZE_B = 2'b00,
    SIZE_H = 2'b01,
    SIZE_W = 2'b10,
    SIZE_D = 2'b11
  } lsu_size_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REQ  = 2'b01,
    S_WAIT = 2'b10,
    S_DONE = 2'b11
  } lsu_state_e;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_MISALIGN = 2'b01,
    ERR_BUS      = 2'b10,
    ERR_TIMEOUT  = 2'b11
  } lsu_err_e;

  // Request fields still needed after the accept cycle.
  typedef struct packed {
    logic      we;
    lsu_size_e size;
    logic      is_unsigned;
    logic [2:0] off;
    logic [4:0] rd_idx;
  } lsu_req_t;

  function automatic logic is_misaligned(lsu_size_e size, logic [2:0] off);
    case (size)
      SIZE_H:  return off[0];
      SIZE_W:  return |off[1:0];
      SIZE_D:  return |off;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] size_mask(lsu_size_e size);
    case (size)
      SIZE_H:  return 8'h03;
      SIZE_W:  return 8'h0F;
      SIZE_D:  return 8'hFF;
      default: return 8'h01;
    endcase
  endfunction

endpackage

// File: rtl/ysyx_22050368_lsu_if.sv
// Memory-side valid/ready bus between the LSU (master) and memory (slave).
interface ysyx_22050368_lsu_if;
  logic        mem_req_valid_o;
  logic        mem_req_ready_i;
  logic [63:0] mem_addr_o;
  logic        mem_we_o;
  logic [7:0]  mem_wmask_o;
  logic [63:0] mem_wdata_o;
  logic        mem_rsp_valid_i;
  logic [63:0] mem_rdata_i;
  logic        mem_err_i;

  modport master (
    output mem_req_valid_o, mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o,
    input  mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i, mem_err_i
  );

  modport slave (
    input  mem_req_valid_o, mem_addr_o, mem_we_o, mem_wmask_o, mem_wdata_o,
    output mem_req_ready_i, mem_rsp_valid_i, mem_rdata_i, mem_err_i
  );
endinterface

// File: rtl/ysyx_22050368_lsu_align.sv
// Combinational datapath: misalignment check and store-lane placement on the
// request side, load-lane extraction and sign/zero extension on the response side.
module ysyx_22050368_lsu_align
  import ysyx_22050368_lsu_pkg::*;
(
  input  lsu_size_e   i_req_size,
  input  logic [2:0]  i_req_off,
  input  logic [63:0] i_req_wdata,
  output logic        o_misaligned,
  output logic [7:0]  o_wmask,
  output logic [63:0] o_wdata,
  input  lsu_size_e   i_rsp_size,
  input  logic [2:0]  i_rsp_off,
  input  logic        i_rsp_unsigned,
  input  logic [63:0] i_rdata,
  output logic [63:0] o_load_data
);

  logic [63:0] w_shifted;

  assign o_misaligned = is_misaligned(i_req_size, i_req_off);
  assign o_wmask      = size_mask(i_req_size) << i_req_off;
  assign o_wdata      = i_req_wdata << {i_req_off, 3'b000};
  assign w_shifted    = i_rdata >> {i_rsp_off, 3'b000};

  always_comb begin
    // NOTE: always_comb assigns the output on every path (default arm included) so no latch is inferred.
    case (i_rsp_size)
      SIZE_B:  o_load_data = i_rsp_unsigned ? {56'b0, w_shifted[7:0]}
                                            : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SIZE_H:  o_load_data = i_rsp_unsigned ? {48'b0, w_shifted[15:0]}
                                            : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SIZE_W:  o_load_data = i_rsp_unsigned ? {32'b0, w_shifted[31:0]}
                                            : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: o_load_data = w_shifted;
    endcase
  end

endmodule

// File: rtl/ysyx_22050368_lsu.sv
// Load/store unit: accepts one memory op from execute, runs it over the valid/ready
// bus and returns a single-cycle writeback record; busy_o stalls upstream meanwhile.
module ysyx_22050368_lsu
  import ysyx_22050368_lsu_pkg::*;
#(
  parameter int TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_we_i,
  input  logic [1:0]  req_size_i,
  input  logic        req_unsigned_i,
  input  logic [63:0] req_addr_i,
  input  logic [63:0] req_wdata_i,
  input  logic [4:0]  req_rd_idx_i,
  ysyx_22050368_lsu_if.master mem,
  output logic        wb_valid_o,
  output logic        wb_we_o,
  output logic [4:0]  wb_rd_idx_o,
  output logic [63:0] wb_data_o,
  output logic        err_o,
  output logic [1:0]  err_cause_o,
  output logic        busy_o
);

  localparam int CNT_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'((TIMEOUT_CYC > 0) ? TIMEOUT_CYC - 1 : 0);

  lsu_state_e  r_state, w_state_n;
  lsu_req_t    r_req;
  logic [CNT_W-1:0] r_cnt;
  logic [63:0] r_mem_addr, r_mem_wdata;
  logic [7:0]  r_mem_wmask;
  logic        r_mem_we;
  logic        r_wb_we, r_err;
  logic [4:0]  r_wb_rd_idx;
  logic [63:0] r_wb_data;
  lsu_err_e    r_err_cause;

  logic        w_misaligned, w_timeout, w_accept;
  logic [7:0]  w_wmask;
  logic [63:0] w_wdata, w_load_data;

  ysyx_22050368_lsu_align u_align (
    .i_req_size     (lsu_size_e'(req_size_i)),
    .i_req_off      (req_addr_i[2:0]),
    .i_req_wdata    (req_wdata_i),
    .o_misaligned   (w_misaligned),
    .o_wmask        (w_wmask),
    .o_wdata        (w_wdata),
    .i_rsp_size     (r_req.size),
    .i_rsp_off      (r_req.off),
    .i_rsp_unsigned (r_req.is_unsigned),
    .i_rdata        (mem.mem_rdata_i),
    .o_load_data    (w_load_data)
  );

  assign w_accept  = (r_state == S_IDLE) && req_valid_i;
  assign w_timeout = (TIMEOUT_CYC != 0) && (r_cnt == CNT_LAST);

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_n;
  end

  always_comb begin
    w_state_n = r_state;
    case (r_state)
      S_IDLE: if (req_valid_i) w_state_n = w_misaligned ? S_DONE : S_REQ;
      S_REQ:  if (mem.mem_req_ready_i) w_state_n = S_WAIT;
      S_WAIT: if (mem.mem_rsp_valid_i || w_timeout) w_state_n = S_DONE;
      default: w_state_n = S_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_req       <= '0;
      r_cnt       <= '0;
      r_mem_addr  <= '0;
      r_mem_we    <= 1'b0;
      r_mem_wmask <= '0;
      r_mem_wdata <= '0;
      r_wb_we     <= 1'b0;
      r_wb_rd_idx <= '0;
      r_wb_data   <= '0;
      r_err       <= 1'b0;
      r_err_cause <= ERR_NONE;
    end else begin
      if (w_accept) begin
        r_req       <= '{we: req_we_i, size: lsu_size_e'(req_size_i),
                         is_unsigned: req_unsigned_i, off: req_addr_i[2:0],
                         rd_idx: req_rd_idx_i};
        r_mem_addr  <= {req_addr_i[63:3], 3'b000};
        r_mem_we    <= req_we_i;
        r_mem_wmask <= req_we_i ? w_wmask : 8'h00;
        r_mem_wdata <= w_wdata;
        r_wb_rd_idx <= req_rd_idx_i;
        if (w_misaligned) begin
          r_err       <= 1'b1;
          r_err_cause <= ERR_MISALIGN;
        end
      end

      if (r_state == S_REQ) r_cnt <= '0;

      if (r_state == S_WAIT) begin
        // A response on the final timeout cycle takes priority over the timeout.
        if (mem.mem_rsp_valid_i) begin
          r_err       <= mem.mem_err_i;
          r_err_cause <= mem.mem_err_i ? ERR_BUS : ERR_NONE;
          r_wb_we     <= !r_req.we && !mem.mem_err_i;
          r_wb_data   <= (!r_req.we && !mem.mem_err_i) ? w_load_data : '0;
        end else if (w_timeout) begin
          r_err       <= 1'b1;
          r_err_cause <= ERR_TIMEOUT;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end

      if (r_state == S_DONE) begin
        r_wb_we     <= 1'b0;
        r_wb_data   <= '0;
        r_err       <= 1'b0;
        r_err_cause <= ERR_NONE;
      end
    end
  end

  assign req_ready_o         = (r_state == S_IDLE);
  assign busy_o              = (r_state != S_IDLE);
  assign mem.mem_req_valid_o = (r_state == S_REQ);
  assign mem.mem_addr_o      = r_mem_addr;
  assign mem.mem_we_o        = r_mem_we;
  assign mem.mem_wmask_o     = r_mem_wmask;
  assign mem.mem_wdata_o     = r_mem_wdata;

  assign wb_valid_o  = (r_state == S_DONE);
  assign wb_we_o     = r_wb_we;
  assign wb_rd_idx_o = r_wb_rd_idx;
  assign wb_data_o   = r_wb_data;
  assign err_o       = r_err;
  assign err_cause_o = r_err_cause;

endmodule
